// File: rtl/syst_ws_array.sv
// rtl/syst_ws_array.sv - weight-stationary systolic array y = W*x; define SYST_WS_RELU_EN to clamp negative results to 0
module syst_ws_array #(
    parameter int  ROWS      = 4,
    parameter int  COLS      = 4,
    parameter int  X_WIDTH   = 8,
    parameter int  W_WIDTH   = 8,
    localparam int ACC_WIDTH = X_WIDTH + W_WIDTH + $clog2(COLS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_start_i,
    input  logic                      w_valid_i,
    input  logic [COLS*W_WIDTH-1:0]   w_data_i,
    output logic                      w_ready_o,
    input  logic                      x_valid_i,
    input  logic [COLS*X_WIDTH-1:0]   x_data_i,
    output logic                      x_ready_o,
    output logic                      y_valid_o,
    output logic [ROWS*ACC_WIDTH-1:0] y_data_o,
    output logic                      busy_o
);
    localparam int LAT  = ROWS + COLS;
    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IF_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [RC_W-1:0]             row_cnt;
    logic [IF_W-1:0]             inflight;
    logic                        w_acc, x_acc;
    logic signed [W_WIDTH-1:0]   w_q     [ROWS][COLS];
    logic signed [X_WIDTH-1:0]   col_in  [COLS];
    logic signed [X_WIDTH-1:0]   x_reg   [ROWS-1][COLS];
    logic signed [ACC_WIDTH-1:0] psum    [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0] row_out [ROWS];
    logic [LAT-2:0]              v_pipe;

    assign w_acc  = w_valid_i && w_ready_o;
    assign x_acc  = x_valid_i && x_ready_o;
    assign busy_o = (state_q == LOAD) || (state_q == DRAIN) || (inflight != '0);

    // Control state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next state and handshake readiness; DRAIN leaves as the last vector retires
    always_comb begin
        state_d   = state_q;
        w_ready_o = 1'b0;
        x_ready_o = 1'b0;
        case (state_q)
            EMPTY: if (load_start_i) state_d = LOAD;
            LOAD: begin
                w_ready_o = 1'b1;
                if (w_valid_i && row_cnt == RC_W'(ROWS - 1)) state_d = RUN;
            end
            RUN: begin
                x_ready_o = 1'b1;
                if (load_start_i) state_d = DRAIN;
            end
            DRAIN: if (inflight <= IF_W'(1)) state_d = LOAD;
            default: state_d = EMPTY;
        endcase
    end

    // Weight rows are written in order; row counter wraps after the last row
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_cnt <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_q[r][c] <= '0;
        end else if (w_acc) begin
            row_cnt <= (row_cnt == RC_W'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
            for (int r = 0; r < ROWS; r++)
                if (row_cnt == RC_W'(r))
                    for (int c = 0; c < COLS; c++)
                        w_q[r][c] <= w_data_i[c*W_WIDTH +: W_WIDTH];
        end
    end

    // In-flight tracker: the newest accepted vector sets the remaining latency
    always_ff @(posedge clk_i) begin
        if (rst_i)                 inflight <= '0;
        else if (x_acc)            inflight <= IF_W'(LAT);
        else if (inflight != '0)   inflight <= inflight - 1'b1;
    end

    // Valid travels alongside the data wavefront
    always_ff @(posedge clk_i) begin
        if (rst_i) v_pipe <= '0;
        else       v_pipe <= {v_pipe[LAT-3:0], x_acc};
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skew
        logic signed [X_WIDTH-1:0] x_gated;
        assign x_gated = x_acc ? x_data_i[j*X_WIDTH +: X_WIDTH] : '0;
        if (j == 0) begin : g_direct
            assign col_in[j] = x_gated;
        end else begin : g_delay
            logic signed [X_WIDTH-1:0] sk [j];
            // Column j enters the array j cycles after column 0
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int d = 0; d < j; d++) sk[d] <= '0;
                end else begin
                    sk[0] <= x_gated;
                    for (int d = 1; d < j; d++) sk[d] <= sk[d-1];
                end
            end
            assign col_in[j] = sk[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic signed [X_WIDTH-1:0]   x_in;
            logic signed [ACC_WIDTH-1:0] p_in;
            logic signed [ACC_WIDTH-1:0] prod;
            if (i == 0) begin : g_xtop
                assign x_in = col_in[j];
            end else begin : g_xpass
                assign x_in = x_reg[i-1][j];
            end
            if (j == 0) begin : g_pzero
                assign p_in = '0;
            end else begin : g_ppass
                assign p_in = psum[i][j-1];
            end
            assign prod = ACC_WIDTH'(w_q[i][j]) * ACC_WIDTH'(x_in);

            // Multiply-accumulate: partial sum moves one column right per cycle
            always_ff @(posedge clk_i) begin
                if (rst_i) psum[i][j] <= '0;
                else       psum[i][j] <= p_in + prod;
            end

            if (i < ROWS - 1) begin : g_xfwd
                // Activation moves one row down per cycle
                always_ff @(posedge clk_i) begin
                    if (rst_i) x_reg[i][j] <= '0;
                    else       x_reg[i][j] <= x_in;
                end
            end
        end

        localparam int D = ROWS - 1 - i;
        if (D == 0) begin : g_nodesk
            assign row_out[i] = psum[i][COLS-1];
        end else begin : g_desk
            logic signed [ACC_WIDTH-1:0] dq [D];
            // Upper rows finish early; hold them until the bottom row catches up
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int d = 0; d < D; d++) dq[d] <= '0;
                end else begin
                    dq[0] <= psum[i][COLS-1];
                    for (int d = 1; d < D; d++) dq[d] <= dq[d-1];
                end
            end
            assign row_out[i] = dq[D-1];
        end
    end

    // Output beat: aligned results captured together, held between beats
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_valid_o <= 1'b0;
            y_data_o  <= '0;
        end else begin
            y_valid_o <= v_pipe[LAT-2];
            if (v_pipe[LAT-2]) begin
                for (int r = 0; r < ROWS; r++) begin
`ifdef SYST_WS_RELU_EN
                    y_data_o[r*ACC_WIDTH +: ACC_WIDTH] <= row_out[r][ACC_WIDTH-1] ? '0 : row_out[r];
`else
                    y_data_o[r*ACC_WIDTH +: ACC_WIDTH] <= row_out[r];
`endif
                end
            end
        end
    end
endmodule

// File: doc/syst_ws_array.md
Name: syst_ws_array

Overview:
Parametrised weight-stationary systolic array computing y = W·x, where W is ROWS×COLS and x has COLS elements.
- Weights are loaded row by row through a handshake and held stationary in the PEs.
- Input vectors stream in at one per cycle, skewed internally. Results are de-skewed so all ROWS outputs appear together in one beat.
- Generalises the fixed 4×4 array: arbitrary dimensions, weight-load FSM, input/output alignment, drain-safe reload, one shared valid.

Parameters:
ROWS, 4, number of array rows = number of outputs per vector
COLS, 4, number of array columns = input vector length
X_WIDTH, 8, signed activation width
W_WIDTH, 8, signed weight width
ACC_WIDTH, X_WIDTH+W_WIDTH+$clog2(COLS), derived localparam, signed result width (18 at defaults)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
load_start_i  in  1  request a (re)load of all weights
w_valid_i  in  1  weight row valid
w_data_i  in  COLS*W_WIDTH  one weight row; element j at [j*W_WIDTH +: W_WIDTH]
w_ready_o  out  1  weight row accepted when w_valid_i && w_ready_o
x_valid_i  in  1  input vector valid
x_data_i  in  COLS*X_WIDTH  input vector; x[j] at [j*X_WIDTH +: X_WIDTH]
x_ready_o  out  1  vector accepted when x_valid_i && x_ready_o
y_valid_o  out  1  result beat valid (single cycle, no backpressure)
y_data_o  out  ROWS*ACC_WIDTH  y[i] at [i*ACC_WIDTH +: ACC_WIDTH]
busy_o  out  1  high in LOAD, in DRAIN, or while any vector is in flight

Behaviour:
Reset:
- FSM goes to EMPTY; all weights are 0; all skew/pipeline/de-skew registers and valids are 0.
- Outputs: y_valid_o=0, y_data_o=0, w_ready_o=0, x_ready_o=0, busy_o=0.
- Reset mid-operation discards in-flight vectors and partially loaded weights. No y_valid_o follows.

FSM states:
- EMPTY: load_start_i -> LOAD.
- LOAD: w_ready_o=1; x_ready_o=0.
  - Each accepted beat writes row row_cnt, then row_cnt++.
  - Accepting row ROWS-1 -> RUN, with row_cnt cleared.
  - load_start_i is ignored in LOAD.
- RUN: x_ready_o=1; w_ready_o=0.
  - load_start_i -> DRAIN.
  - An x_valid_i in the same cycle as load_start_i is still accepted and uses the old weights.
- DRAIN: x_ready_o=0, w_ready_o=0.
  - An in-flight counter is loaded with LAT on every accept and decrements to 0 otherwise.
  - Counter==0 -> LOAD.
  - Weights never change while any vector is in flight.

Datapath:
- Column j input is delayed j cycles by the skew registers.
- x travels down rows with one register per PE; partial sums travel across columns with one register per PE. Column 0 psum input is 0.
- Row i output is delayed by ROWS-1-i de-skew registers.
- Fixed latency LAT = ROWS+COLS cycles: a vector accepted at edge k gives y_valid_o=1 in the cycle after edge k+LAT−1.
- Throughput: one vector per cycle; back-to-back accepts give back-to-back y_valid_o beats.
- y_data_o holds its last value when y_valid_o=0.

Arithmetic:
- Signed two's complement throughout; products are sign-extended to ACC_WIDTH.
- No overflow is possible by construction (worst case (−2^(X−1))·(−2^(W−1))·COLS fits), so no saturation is applied.
- w_valid_i outside LOAD and x_valid_i outside RUN are ignored; they cause no state change.

Optional Feature:
SYST_WS_RELU_EN
- Defined: each y[i] is clamped to 0 when negative, registered in the final de-skew stage. LAT is unchanged.
- Undefined: raw signed sums are output.

Test Plan:
1. ROWS=COLS=4. Reset, load_start, then W[i][j]=4i+j+1 over 4 beats, then x=(1,2,3,4) -> y=(30,70,110,150) exactly 8 cycles after the accept; busy_o falls 1 cycle later.
2. Stream x=(1,2,3,4), (0,0,0,1), (1,1,1,1) on 3 consecutive cycles with W as in scenario 1 -> 3 consecutive y_valid_o beats: (30,70,110,150), (4,8,12,16), (10,26,42,58).
3. W all −1, x=(127,127,127,127) -> y=−508 for each row without the macro; y=0 for each row with SYST_WS_RELU_EN.
4. W all −128, x all −128 -> y=65536 for each row, with no wrap at ACC_WIDTH=18.
5. Issue load_start_i 2 cycles after an accept -> x_ready_o falls; the old vector's result still uses the old weights; w_ready_o rises only after 6 more cycles (counter reaches 0); a new vector is accepted after 4 rows load.
6. Assert rst_i after 2 of 4 weight rows -> all outputs return to reset values; the next x_valid_i is not accepted until a full reload completes.
